// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register-access slave.
package spi_reg_pkg;

    localparam int unsigned SPI_BYTE_W     = 8;
    localparam int unsigned SPI_FRAME_BITS = 16;
    localparam int unsigned SPI_RW_BIT     = 7;

    // Frame decoder states; StWaitCs is the reset state, so a frame already
    // in flight at reset is skipped.
    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StData,
        StTail,
        StWaitCs
    } spi_state_e;

endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, plus registered
// rise/fall detection. The level output is aligned with the edge pulses, so a
// consumer sees the settled value of the pin in the same cycle as the edge.
module spi_in_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              level_q;
    logic              rise_q;
    logic              fall_q;

    // Synchronizer chain, then one more flop to compare against for edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[STAGES-2:0], din};
            level_q <= sync_q[STAGES-1];
            rise_q  <= sync_q[STAGES-1] & ~level_q;
            fall_q  <= ~sync_q[STAGES-1] & level_q;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 register-access slave. It oversamples the SPI pins with the
// system clock, decodes two-byte frames {rw, addr} + data and issues one write
// strobe or one read request per complete frame.
// Optional feature: define SPI_READBACK_EN to honour the rw bit and return
// read data on spi_miso; without it every complete frame is a write.
module spi_reg_slave
    import spi_reg_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ADDR_W      = 7
) (
    input  logic              clk_12mhz,
    input  logic              rst,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    input  logic              spi_cs,
    output logic              spi_miso,
    output logic              wr_stb,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              rd_stb,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              frame_err
);

    localparam logic [4:0] CNT_CMD_LAST   = 5'(SPI_BYTE_W - 1);
    localparam logic [4:0] CNT_FRAME_LAST = 5'(SPI_FRAME_BITS - 1);
    localparam logic [4:0] CNT_FULL       = 5'(SPI_FRAME_BITS);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic cs_lvl, cs_rise, cs_fall;

    spi_in_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk   (clk_12mhz),
        .rst   (rst),
        .din   (spi_clk),
        .level (sclk_lvl),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_in_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk   (clk_12mhz),
        .rst   (rst),
        .din   (spi_mosi),
        .level (mosi_lvl),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    spi_in_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk   (clk_12mhz),
        .rst   (rst),
        .din   (spi_cs),
        .level (cs_lvl),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sclk_lvl, mosi_rise, mosi_fall};

    spi_state_e            state_q, state_d;
    logic [4:0]            cnt_q;
    logic [SPI_BYTE_W-1:0] rx_q;
    logic [SPI_BYTE_W-1:0] cmd_q;
    logic                  overrun_q;
    logic                  wr_stb_q, frame_err_q;
    logic [ADDR_W-1:0]     wr_addr_q;
    logic [7:0]            wr_data_q;
    logic                  wr_stb_d, rd_stb_d, frame_err_d;

    logic                  in_frame;
    logic                  cmd_done;
    logic                  frame_done;
    logic [SPI_BYTE_W-1:0] shift_in;
    logic                  is_read;
    logic                  cmd_is_read;

    assign in_frame   = (state_q == StCmd) || (state_q == StData);
    assign cmd_done   = (state_q == StCmd) && sclk_rise && (cnt_q == CNT_CMD_LAST);
    assign frame_done = (state_q == StData) && sclk_rise && (cnt_q == CNT_FRAME_LAST);
    // Byte as it will look once the current MOSI bit is shifted in.
    assign shift_in   = {rx_q[SPI_BYTE_W-2:0], mosi_lvl};

    // FSM state register.
    always_ff @(posedge clk_12mhz or negedge rst) begin
        if (!rst) begin
            state_q <= StWaitCs;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; a CS rise aborts any state, an SCK rise in the
    // same cycle has already been accounted for by frame_done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StWaitCs: if (cs_lvl) state_d = StIdle;
            StIdle:   if (cs_fall) state_d = StCmd;
            StCmd: begin
                if (cs_rise)       state_d = StIdle;
                else if (cmd_done) state_d = StData;
            end
            StData: begin
                if (cs_rise)         state_d = StIdle;
                else if (frame_done) state_d = StTail;
            end
            StTail:   if (cs_rise) state_d = StIdle;
            default:  state_d = StWaitCs;
        endcase
    end

    // FSM outputs: strobe and error requests, registered below.
    always_comb begin
        wr_stb_d    = 1'b0;
        rd_stb_d    = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            StCmd: begin
                rd_stb_d    = cmd_done && cmd_is_read && !cs_rise;
                frame_err_d = cs_rise;
            end
            StData: begin
                wr_stb_d    = frame_done && !is_read;
                frame_err_d = cs_rise && !frame_done;
            end
            StTail: begin
                frame_err_d = cs_rise && (overrun_q || sclk_rise);
            end
            default: ;
        endcase
    end

    // Bit counter, receive shift register, command byte and overrun flag.
    always_ff @(posedge clk_12mhz or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            rx_q      <= '0;
            cmd_q     <= '0;
            overrun_q <= 1'b0;
        end else if ((state_q == StIdle) && cs_fall) begin
            cnt_q     <= '0;
            rx_q      <= '0;
            cmd_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (in_frame && sclk_rise) begin
                rx_q <= shift_in;
                if (cnt_q < CNT_FULL) cnt_q <= cnt_q + 5'd1;
            end
            if (cmd_done) cmd_q <= shift_in;
            if ((state_q == StTail) && sclk_rise) overrun_q <= 1'b1;
        end
    end

    // Registered write port and error pulse.
    always_ff @(posedge clk_12mhz or negedge rst) begin
        if (!rst) begin
            wr_stb_q    <= 1'b0;
            frame_err_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            wr_stb_q    <= wr_stb_d;
            frame_err_q <= frame_err_d;
            if (wr_stb_d) begin
                wr_addr_q <= cmd_q[ADDR_W-1:0];
                wr_data_q <= shift_in;
            end
        end
    end

    assign wr_stb    = wr_stb_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_err = frame_err_q;

`ifdef SPI_READBACK_EN
    logic                  rd_stb_q;
    logic                  load_tx_q;
    logic [ADDR_W-1:0]     rd_addr_q;
    logic [SPI_BYTE_W-1:0] tx_q;
    logic                  miso_q;
    logic                  tx_shift;

    assign is_read     = cmd_q[SPI_RW_BIT];
    assign cmd_is_read = shift_in[SPI_RW_BIT];
    assign tx_shift    = (state_q == StData) && is_read && sclk_fall;

    // Read request; rd_addr stays put until the next read request.
    always_ff @(posedge clk_12mhz or negedge rst) begin
        if (!rst) begin
            rd_stb_q  <= 1'b0;
            load_tx_q <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            rd_stb_q  <= rd_stb_d;
            load_tx_q <= rd_stb_d;
            if (rd_stb_d) rd_addr_q <= shift_in[ADDR_W-1:0];
        end
    end

    // TX shift register: rd_data captured one cycle after rd_stb, shifted
    // out MSB first on each SCK fall of the data byte.
    always_ff @(posedge clk_12mhz or negedge rst) begin
        if (!rst) begin
            tx_q   <= '0;
            miso_q <= 1'b0;
        end else begin
            if (load_tx_q) begin
                tx_q <= rd_data;
            end else if (tx_shift) begin
                tx_q <= {tx_q[SPI_BYTE_W-2:0], 1'b0};
            end
            if ((state_q == StIdle) || (state_q == StWaitCs)) begin
                miso_q <= 1'b0;
            end else if (tx_shift) begin
                miso_q <= tx_q[SPI_BYTE_W-1];
            end
        end
    end

    // Gate with the raw pin so MISO drops as soon as CS is released.
    assign spi_miso = miso_q & ~spi_cs;
    assign rd_stb   = rd_stb_q;
    assign rd_addr  = rd_addr_q;
`else
    logic unused_cfg;

    assign is_read     = 1'b0;
    assign cmd_is_read = 1'b0;
    assign spi_miso    = 1'b0;
    assign rd_stb      = 1'b0;
    assign rd_addr     = '0;
    assign unused_cfg  = ^{rd_data, rd_stb_d, cmd_q[SPI_RW_BIT]};
`endif

endmodule

// File: tb/tb_spi_reg_slave.sv
// Scoreboard bench for spi_reg_slave: the driver pushes the expected strobes
// for each frame, a monitor pops and compares whenever the DUT pulses one.
module tb_spi_reg_slave;

    localparam int HALF = 6;
    localparam logic [1:0] KW = 2'd0;
    localparam logic [1:0] KR = 2'd1;
    localparam logic [1:0] KE = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [6:0] addr;
        logic [7:0] data;
    } ev_t;

    logic       clk_12mhz = 1'b0;
    logic       rst       = 1'b0;
    logic       spi_clk   = 1'b0;
    logic       spi_mosi  = 1'b0;
    logic       spi_cs    = 1'b1;
    logic       spi_miso;
    logic       wr_stb;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_stb;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;
    logic       frame_err;

    ev_t  exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    logic miso_hi = 1'b0;

    // Register bank stand-in: side-effect-free read of two known values.
    assign rd_data = (rd_addr == 7'h03) ? 8'hA5 : 8'h5A;

    spi_reg_slave #(.SYNC_STAGES(2), .ADDR_W(7)) dut (
        .clk_12mhz (clk_12mhz),
        .rst       (rst),
        .spi_clk   (spi_clk),
        .spi_mosi  (spi_mosi),
        .spi_cs    (spi_cs),
        .spi_miso  (spi_miso),
        .wr_stb    (wr_stb),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_stb    (rd_stb),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .frame_err (frame_err)
    );

    always #5 clk_12mhz = ~clk_12mhz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_event(input string name, input logic [1:0] kind,
                               input logic [6:0] addr, input logic [7:0] data);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected pulse addr 0x%0h data 0x%0h, none expected",
                     name, addr, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== kind || e.addr !== addr || e.data !== data) begin
                errors++;
                $display("FAIL %s: got kind %0d addr 0x%0h data 0x%0h expected kind %0d addr 0x%0h data 0x%0h",
                         name, kind, addr, data, e.kind, e.addr, e.data);
            end
        end
    endtask

    task automatic expect_ev(input logic [1:0] kind, input logic [6:0] addr,
                             input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every strobe the DUT emits against the scoreboard.
    always @(negedge clk_12mhz) begin
        if (rst) begin
            if (wr_stb)    check_event("wr_stb", KW, wr_addr, wr_data);
            if (rd_stb)    check_event("rd_stb", KR, rd_addr, 8'h00);
            if (frame_err) check_event("frame_err", KE, 7'h00, 8'h00);
            if (spi_miso)  miso_hi = 1'b1;
        end
    end

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk_12mhz);
    endtask

    task automatic cs_low();
        spi_cs = 1'b0;
        clk_wait(HALF);
    endtask

    task automatic cs_high();
        clk_wait(HALF);
        spi_cs   = 1'b1;
        spi_mosi = 1'b0;
        clk_wait(12);
    endtask

    // One mode-0 bit: data set while SCK low, MISO sampled at the rise.
    task automatic send_bit(input logic b, input logic cs_on_rise, output logic m);
        spi_mosi = b;
        clk_wait(HALF);
        spi_clk = 1'b1;
        m = spi_miso;
        if (cs_on_rise) spi_cs = 1'b1;
        clk_wait(HALF);
        spi_clk = 1'b0;
    endtask

    task automatic frame(input logic [31:0] bits, input int n, input logic cs_at_last,
                         output logic [7:0] rx);
        logic m;
        rx = 8'h00;
        cs_low();
        for (int i = 0; i < n; i++) begin
            send_bit(bits[n-1-i], cs_at_last && (i == n - 1), m);
            if (i >= 8 && i < 16) rx = {rx[6:0], m};
        end
        if (cs_at_last) clk_wait(12);
        else cs_high();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"},      {31'd0, spi_miso},  32'd0);
        check({tag, "_wr_stb"},    {31'd0, wr_stb},    32'd0);
        check({tag, "_wr_addr"},   {25'd0, wr_addr},   32'd0);
        check({tag, "_wr_data"},   {24'd0, wr_data},   32'd0);
        check({tag, "_rd_stb"},    {31'd0, rd_stb},    32'd0);
        check({tag, "_rd_addr"},   {25'd0, rd_addr},   32'd0);
        check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    endtask

    initial begin
        logic [7:0] rx;
        logic       m;

        clk_wait(5);
        check_reset_outputs("rst");
        rst = 1'b1;
        clk_wait(10);

        // Plain write.
        expect_ev(KW, 7'h01, 8'h11);
        frame(32'h0000_0111, 16, 1'b0, rx);

        // rw=1 frame: a read when readback is built, otherwise a write.
`ifdef SPI_READBACK_EN
        expect_ev(KR, 7'h03, 8'h00);
        frame(32'h0000_8300, 16, 1'b0, rx);
        check("read_miso_0x83", {24'd0, rx}, 32'h0000_00A5);
`else
        expect_ev(KW, 7'h03, 8'h00);
        frame(32'h0000_8300, 16, 1'b0, rx);
        check("miso_zero_0x83", {24'd0, rx}, 32'h0000_0000);
`endif

        // Truncated at 11 bits, then a normal frame.
        expect_ev(KE, 7'h00, 8'h00);
        frame(32'h0000_0155, 11, 1'b0, rx);
        expect_ev(KW, 7'h02, 8'h05);
        frame(32'h0000_0205, 16, 1'b0, rx);

        // 24-bit overrun: write on bit 16, error at CS rise.
        expect_ev(KW, 7'h04, 8'h0F);
        expect_ev(KE, 7'h00, 8'h00);
        frame(32'h0004_0FFF, 24, 1'b0, rx);

        // Reset mid-frame, released with CS still low: rest of frame ignored.
        cs_low();
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, m);
        rst = 1'b0;
        clk_wait(3);
        check_reset_outputs("mid_rst");
        rst = 1'b1;
        for (int i = 0; i < 11; i++) send_bit(i[0], 1'b0, m);
        cs_high();
        expect_ev(KW, 7'h06, 8'h77);
        frame(32'h0000_0677, 16, 1'b0, rx);

`ifdef SPI_READBACK_EN
        expect_ev(KR, 7'h05, 8'h00);
        frame(32'h0000_853C, 16, 1'b0, rx);
        check("read_miso_0x85", {24'd0, rx}, 32'h0000_005A);
`else
        expect_ev(KW, 7'h05, 8'h3C);
        frame(32'h0000_853C, 16, 1'b0, rx);
        check("miso_zero_0x85", {24'd0, rx}, 32'h0000_0000);
`endif

        // CS rises together with the 16th SCK rise: still a valid frame.
        expect_ev(KW, 7'h07, 8'h81);
        frame(32'h0000_0781, 16, 1'b1, rx);

        clk_wait(20);
`ifndef SPI_READBACK_EN
        check("miso_never_high", {31'd0, miso_hi}, 32'd0);
`endif
        check("events_outstanding", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
